// File: rtl/mac_axi_tx_pkg.sv
// rtl/mac_axi_tx_pkg.sv - shared types, response codes and helpers for the AXI-to-MAC TX buffer
package mac_axi_tx_pkg;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DONE
    } tx_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         MIN_FRAME_BYTES = 60;

    // MAC byte-enable code for the final word: 00=1 byte ... 11=4 bytes
    function automatic logic [1:0] len_to_ben(input logic [1:0] len_lsb);
        return len_lsb - 2'd1;
    endfunction

endpackage

// File: rtl/mac_tx_pkt_ram.sv
// rtl/mac_tx_pkt_ram.sv - simple dual-port byte-write packet RAM, 1-cycle read latency (_ARCH_XIL selects block RAM)
module mac_tx_pkt_ram #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

`ifdef _ARCH_XIL
    (* ram_style = "block" *) logic [DW-1:0] mem [0:2**AW-1];
`else
    logic [DW-1:0] mem [0:2**AW-1];
`endif

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_to_mac_tx_buffer.sv
// rtl/axi_to_mac_tx_buffer.sv - AXI4-Lite filled packet buffer streamed to the MAC TX port; option TX_MIN_PAD_EN
module axi_to_mac_tx_buffer
    import mac_axi_tx_pkg::*;
#(
    parameter int          _dat_w_mac         = 32,
    parameter int          _ben_w_mac         = 2,
    parameter int          _addr_w_mem        = 14,
    parameter int          _dat_w_mem         = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] CTRL_ADDR          = 32'h0001_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic                            mac_txwa_i,
    output logic                            mac_txwr_o,
    output logic [_dat_w_mac-1:0]           mac_txd_o,
    output logic [_ben_w_mac-1:0]           mac_txben_o,
    output logic                            mac_txsop_o,
    output logic                            mac_txeop_o,
    output logic                            tx_busy_o,
    output logic                            tx_done_o
);

    localparam int AW      = _addr_w_mem;
    localparam int WI      = _addr_w_mem + 1;
    localparam int DEPTH   = 2 ** _addr_w_mem;
    localparam int MAX_LEN = 4 * DEPTH;

    if (_dat_w_mac != 32 || _ben_w_mac != 2) begin : g_bad_width
        $error("axi_to_mac_tx_buffer: only 32-bit MAC data with 2-bit byte enable is supported");
    end

    wr_state_t wr_state, wr_state_nxt;
    tx_state_t tx_state, tx_state_nxt;

    logic [1:0]             bresp_q, resp_nxt;
    logic                   wr_hs, buf_hit, ctrl_hit, len_ok, tx_start, send;
    logic [_dat_w_mem/8-1:0] ram_we;
    logic [AW-1:0]          raddr;
    logic [_dat_w_mem-1:0]  rdata, tx_word;
    logic [WI-1:0]          nwords, word_idx, words_in, nwords_in;
    logic [1:0]             last_ben, ben_in;

    assign S_AXI_AWREADY = wr_hs;
    assign S_AXI_WREADY  = wr_hs;
    assign S_AXI_BVALID  = (wr_state == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign tx_busy_o     = (tx_state != TX_IDLE);
    assign tx_done_o     = (tx_state == TX_DONE);

    // The full data word is range-checked so an oversized length is rejected rather than wrapped
    assign words_in = WI'((S_AXI_WDATA + 32'd3) >> 2);

`ifdef TX_MIN_PAD_EN
    logic [WI-1:0] data_words;
    logic          short_frame;

    assign short_frame = S_AXI_WDATA < C_S_AXI_DATA_WIDTH'(MIN_FRAME_BYTES);
    assign nwords_in   = short_frame ? WI'(MIN_FRAME_BYTES / 4) : words_in;
    assign ben_in      = short_frame ? 2'b11 : len_to_ben(S_AXI_WDATA[1:0]);
    assign tx_word     = (word_idx < data_words) ? rdata : '0;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            data_words <= '0;
        end else if (tx_start) begin
            data_words <= words_in;
        end
    end
`else
    assign nwords_in = words_in;
    assign ben_in    = len_to_ben(S_AXI_WDATA[1:0]);
    assign tx_word   = rdata;
`endif

    always_comb begin
        wr_hs    = (wr_state == WR_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
        buf_hit  = S_AXI_AWADDR < C_S_AXI_ADDR_WIDTH'(DEPTH);
        ctrl_hit = S_AXI_AWADDR == C_S_AXI_ADDR_WIDTH'(CTRL_ADDR);
        len_ok   = (S_AXI_WDATA != '0) && (S_AXI_WDATA <= C_S_AXI_DATA_WIDTH'(MAX_LEN));
        ram_we   = '0;
        tx_start = 1'b0;
        resp_nxt = RESP_SLVERR;
        if (wr_hs && !tx_busy_o) begin
            if (buf_hit) begin
                ram_we   = S_AXI_WSTRB;
                resp_nxt = RESP_OKAY;
            end else if (ctrl_hit && len_ok) begin
                tx_start = 1'b1;
                resp_nxt = RESP_OKAY;
            end
        end

        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_hs) wr_state_nxt = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase

        send = (tx_state == TX_SEND) && (word_idx != nwords) && mac_txwa_i;

        // Leave SEND only once the EOP word is actually on the MAC port
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start) tx_state_nxt = TX_SEND;
            TX_SEND: if (mac_txwr_o && mac_txeop_o) tx_state_nxt = TX_DONE;
            TX_DONE: tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase

        // rdata always holds word_idx; advance the read one word ahead whenever a word is consumed
        if (tx_start) begin
            raddr = '0;
        end else if (send) begin
            raddr = AW'(word_idx + 1'b1);
        end else begin
            raddr = AW'(word_idx);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state <= WR_IDLE;
            tx_state <= TX_IDLE;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_nxt;
            tx_state <= tx_state_nxt;
            if (wr_hs) begin
                bresp_q <= resp_nxt;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            nwords      <= '0;
            last_ben    <= '0;
            word_idx    <= '0;
            mac_txwr_o  <= 1'b0;
            mac_txd_o   <= '0;
            mac_txben_o <= '0;
            mac_txsop_o <= 1'b0;
            mac_txeop_o <= 1'b0;
        end else begin
            if (tx_start) begin
                nwords   <= nwords_in;
                last_ben <= ben_in;
                word_idx <= '0;
            end else if (send) begin
                word_idx <= word_idx + 1'b1;
            end
            mac_txwr_o <= send;
            if (send) begin
                mac_txd_o   <= tx_word;
                mac_txsop_o <= (word_idx == '0);
                mac_txeop_o <= (word_idx == nwords - 1'b1);
                mac_txben_o <= (word_idx == nwords - 1'b1) ? last_ben : 2'b11;
            end else begin
                mac_txsop_o <= 1'b0;
                mac_txeop_o <= 1'b0;
            end
        end
    end

    mac_tx_pkt_ram #(
        .AW (AW),
        .DW (_dat_w_mem)
    ) u_ram (
        .clk   (ACLK),
        .we    (ram_we),
        .waddr (S_AXI_AWADDR[AW-1:0]),
        .wdata (S_AXI_WDATA),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_axi_to_mac_tx_buffer.sv
// tb/tb_axi_to_mac_tx_buffer.sv - directed self-checking bench for axi_to_mac_tx_buffer (honours TX_MIN_PAD_EN)
module tb_axi_to_mac_tx_buffer;

    localparam logic [31:0] CTRL = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, wa;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;
    logic        wr, sop, eop, busy, done;
    logic [31:0] txd;
    logic [1:0]  ben;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  ben;
        logic        busy;
        int          cyc;
    } beat_t;

    beat_t       q[$];
    logic [31:0] exp_w[$];

    always #5 clk = ~clk;

    axi_to_mac_tx_buffer dut (
        .ACLK          (clk),
        .ARESETN       (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .mac_txwa_i    (wa),
        .mac_txwr_o    (wr),
        .mac_txd_o     (txd),
        .mac_txben_o   (ben),
        .mac_txsop_o   (sop),
        .mac_txeop_o   (eop),
        .tx_busy_o     (busy),
        .tx_done_o     (done)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr === 1'b1) q.push_back('{txd, sop, eop, ben, busy, cyc});
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
        chk("aw_w_ready", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", bvalid, 1'b1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin @(posedge clk); #1; n++; end
        chk({tag, "_idle"}, busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q.delete();
        exp_w.delete();
        done_cnt = 0;
    endtask

    task automatic pad_expect(input int len, inout logic [1:0] last_ben);
`ifdef TX_MIN_PAD_EN
        if (len < 60) begin
            while (exp_w.size() < 15) exp_w.push_back(32'h0);
            last_ben = 2'b11;
        end
`endif
    endtask

    task automatic check_pkt(input string tag, input int len, input logic [1:0] hand_ben);
        logic [1:0] lb;
        int n;
        lb = hand_ben;
        pad_expect(len, lb);
        n = exp_w.size();
        chk({tag, "_nwords"}, q.size(), n);
        if (q.size() == n) begin
            foreach (exp_w[i]) begin
                chk($sformatf("%s_w%0d", tag, i),
                    {q[i].sop, q[i].eop, q[i].ben, q[i].busy, q[i].data},
                    {i == 0, i == n - 1, (i == n - 1) ? lb : 2'b11, 1'b1, exp_w[i]});
            end
            chk({tag, "_done_pulse"}, {done_cnt, done_cyc}, {32'd1, q[n-1].cyc + 1});
        end
    endtask

    initial begin
        logic [1:0] r;
        int n, g1, g4, eops;

        aresetn = 1'b0; awaddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wa = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_axi", {awready, wready, bvalid, bresp}, 5'b0);
        chk("rst_mac", {wr, sop, eop, ben, txd}, 37'b0);
        chk("rst_tx", {busy, done}, 2'b0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // AWVALID alone must not be accepted
        awaddr = 32'h0; awvalid = 1'b1;
        @(posedge clk); #1;
        chk("aw_alone_ready", {awready, wready, bvalid}, 3'b0);
        awvalid = 1'b0;
        @(posedge clk); #1;

        // single 4-byte packet
        clear_mon();
        axi_wr(32'h0, 32'h1122_3344, 4'hF, r); chk("t1_buf_resp", r, 2'b00);
        axi_wr(CTRL, 32'd4, 4'hF, r);          chk("t1_ctrl_resp", r, 2'b00);
        wait_idle("t1");
        exp_w.push_back(32'h1122_3344);
        check_pkt("t1", 4, 2'b11);

        // four words, byte-strobed update of word 3, len=13
        clear_mon();
        axi_wr(32'h0, 32'hA0A1_A2A3, 4'hF, r); chk("t2_w0", r, 2'b00);
        axi_wr(32'h1, 32'hB0B1_B2B3, 4'hF, r); chk("t2_w1", r, 2'b00);
        axi_wr(32'h2, 32'hC0C1_C2C3, 4'hF, r); chk("t2_w2", r, 2'b00);
        axi_wr(32'h3, 32'hD0D1_D2D3, 4'hF, r); chk("t2_w3", r, 2'b00);
        axi_wr(32'h3, 32'h1234_5678, 4'b0110, r); chk("t2_strb", r, 2'b00);
        axi_wr(CTRL, 32'd13, 4'hF, r);         chk("t2_ctrl", r, 2'b00);
        wait_idle("t2");
        exp_w = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD034_56D3};
        check_pkt("t2", 13, 2'b00);

        // same packet with a 3-cycle write-available stall mid-packet
        clear_mon();
        axi_wr(CTRL, 32'd13, 4'hF, r); chk("t3_ctrl", r, 2'b00);
        n = 0;
        while (q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("t3_reach2", q.size() >= 2, 1'b1);
        wa = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wa = 1'b1;
        wait_idle("t3");
        exp_w = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD034_56D3};
        check_pkt("t3", 13, 2'b00);
        g1 = 0; g4 = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i].cyc - q[i-1].cyc == 1) g1++;
            else if (q[i].cyc - q[i-1].cyc == 4) g4++;
        end
        chk("t3_gap4", g4, 1);
        chk("t3_gap1", g1, q.size() - 2);

        // writes while busy are rejected and do not disturb the packet
        clear_mon();
        wa = 1'b0;
        axi_wr(CTRL, 32'd13, 4'hF, r);         chk("t4_start", r, 2'b00);
        axi_wr(CTRL, 32'd4, 4'hF, r);          chk("t4_ctrl_busy", r, 2'b10);
        axi_wr(32'h0, 32'hDEAD_BEEF, 4'hF, r); chk("t4_buf_busy", r, 2'b10);
        chk("t4_stalled", {busy, 32'(q.size())}, {1'b1, 32'd0});
        wa = 1'b1;
        wait_idle("t4");
        exp_w = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD034_56D3};
        check_pkt("t4", 13, 2'b00);

        // illegal lengths, addresses and the buffer boundary
        clear_mon();
        axi_wr(CTRL, 32'd0, 4'hF, r);            chk("t5_len0", r, 2'b10);
        axi_wr(CTRL, 32'd65537, 4'hF, r);        chk("t5_len65537", r, 2'b10);
        axi_wr(32'h0002_0000, 32'd4, 4'hF, r);   chk("t5_badaddr", r, 2'b10);
        axi_wr(32'h0000_3FFF, 32'h5555_AAAA, 4'hF, r); chk("t5_lastword", r, 2'b00);
        axi_wr(32'h0000_4000, 32'h5555_AAAA, 4'hF, r); chk("t5_pastend", r, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_tx", {busy, 32'(q.size())}, 33'd0);

        // CTRL write landing in the TX_DONE cycle
        clear_mon();
        wa = 1'b0;
        axi_wr(CTRL, 32'd4, 4'hF, r); chk("t6_start", r, 2'b00);
        wa = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t6_in_done", {done, busy}, 2'b11);
        axi_wr(CTRL, 32'd4, 4'hF, r); chk("t6_done_collide", r, 2'b10);
        chk("t6_no_restart", busy, 1'b0);
        wait_idle("t6");

        // short frame, len=8
        clear_mon();
        axi_wr(CTRL, 32'd8, 4'hF, r); chk("t7_ctrl", r, 2'b00);
        wait_idle("t7");
        exp_w = '{32'hA0A1_A2A3, 32'hB0B1_B2B3};
        check_pkt("t7", 8, 2'b11);

        // reset mid-packet, then a clean packet
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            axi_wr(32'(i), 32'h1000_0000 + 32'(i), 4'hF, r);
        end
        chk("t8_fill_last", r, 2'b00);
        axi_wr(CTRL, 32'd80, 4'hF, r); chk("t8_ctrl", r, 2'b00);
        n = 0;
        while (q.size() < 5 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t8_reach5", q.size() >= 5, 1'b1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        chk("t8_rst_out", {wr, eop, busy, done}, 4'b0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        eops = 0;
        foreach (q[i]) if (q[i].eop) eops++;
        chk("t8_no_eop", eops, 0);
        chk("t8_first", q[0].data, 32'h1000_0000);
        clear_mon();
        axi_wr(32'h0, 32'hCAFE_BABE, 4'hF, r); chk("t8_buf", r, 2'b00);
        axi_wr(CTRL, 32'd4, 4'hF, r);          chk("t8_ctrl2", r, 2'b00);
        wait_idle("t8");
        exp_w.push_back(32'hCAFE_BABE);
        check_pkt("t8", 4, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
